// File: rtl/hazard_unit_if.sv
// Hazard-unit signal bundle: ID operands and ID/EX, EX/MEM control bits in, pipeline controls out.
// HAZARD_STATS_EN adds the two statistics counters to the bundle.
interface hazard_unit_if;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_MR;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       mem_req;
  logic       stall;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       pipe_en;
`ifdef HAZARD_STATS_EN
  logic [15:0] stat_stall_cnt;
  logic [15:0] stat_flush_cnt;
`endif

  // Pipeline side: supplies the observed fields, receives the controls.
  modport master (
    output id_opcode, id_rs1, id_rs2, ex_MR, ex_rd, ex_redirect, mem_req,
`ifdef HAZARD_STATS_EN
    input  stat_stall_cnt, stat_flush_cnt,
`endif
    input  stall, pc_en, ifid_en, ifid_flush, idex_flush, pipe_en
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_MR, ex_rd, ex_redirect, mem_req,
`ifdef HAZARD_STATS_EN
    output stat_stall_cnt, stat_flush_cnt,
`endif
    output stall, pc_en, ifid_en, ifid_flush, idex_flush, pipe_en
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubble, multi-cycle memory freeze, branch/jump flush.
// Optional HAZARD_STATS_EN macro adds saturating stall/flush statistics counters.
module hazard_unit #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  hazard_unit_if.slave hz
);

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_S   = 7'b0100011;

  localparam bit             HAS_WAIT = (MEM_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = HAS_WAIT ? CNT_W'(MEM_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic uses_rs1;
  logic uses_rs2;
  logic lu;
  logic freeze;
  logic redirect_eff;
  logic stall_int;

  always_comb begin
    uses_rs1 = !((hz.id_opcode == OP_LUI) || (hz.id_opcode == OP_JAL));
    uses_rs2 = (hz.id_opcode == OP_R) || (hz.id_opcode == OP_B) || (hz.id_opcode == OP_S);
    lu = hz.ex_MR && (hz.ex_rd != 5'd0) &&
         ((uses_rs1 && (hz.ex_rd == hz.id_rs1)) || (uses_rs2 && (hz.ex_rd == hz.id_rs2)));
  end

  always_comb begin
    freeze = 1'b0;
    case (state_q)
      RUN:     freeze = hz.mem_req && HAS_WAIT;
      MEMWAIT: freeze = (cnt_q != '0);
    endcase
  end

  // A memory op spends MEM_LAT cycles in MEM: one RUN cycle that freezes, then MEMWAIT
  // counts down the remaining freeze cycles and releases on cnt==0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze) begin
            state_q <= MEMWAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        MEMWAIT: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - CNT_ONE;
          else             state_q <= RUN;
        end
      endcase
    end
  end

  // Priority freeze > redirect > load-use; a redirect raised while frozen is simply
  // seen again next cycle because the EX register holding it is frozen too.
  always_comb begin
    redirect_eff = hz.ex_redirect && !freeze;
    stall_int    = lu && !freeze && !hz.ex_redirect;
    if (!rst) begin
      hz.stall      = 1'b1;
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.pipe_en    = 1'b0;
      hz.ifid_flush = 1'b0;
      hz.idex_flush = 1'b0;
    end else begin
      hz.stall      = stall_int;
      hz.pipe_en    = !freeze;
      hz.pc_en      = !freeze && (redirect_eff || !lu);
      hz.ifid_en    = !freeze && (redirect_eff || !lu);
      hz.ifid_flush = redirect_eff;
      hz.idex_flush = redirect_eff;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stat_stall_q;
  logic [15:0] stat_flush_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_q <= '0;
      stat_flush_q <= '0;
    end else begin
      if (stall_int || freeze) stat_stall_q <= sat_inc(stat_stall_q);
      if (redirect_eff)        stat_flush_q <= sat_inc(stat_flush_q);
    end
  end

  assign hz.stat_stall_cnt = stat_stall_q;
  assign hz.stat_flush_cnt = stat_flush_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit (MEM_LAT=3): directed literal cases, then randomized pipeline traffic
// compared every cycle against an age-based behavioural model.
module tb_hazard_unit;
  localparam int MEM_LAT = 3;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hazard_unit_if hif ();

  hazard_unit #(.MEM_LAT(MEM_LAT), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  always #5 clk = ~clk;

  // Model state: how many cycles the op now in MEM has already spent there.
  int age = 0;
`ifdef HAZARD_STATS_EN
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
`endif

  function automatic logic m_lu(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic mr, input logic [4:0] rd);
    bit u1 = !(op == OP_LUI || op == OP_JAL);
    bit u2 = (op == OP_R || op == OP_B || op == OP_S);
    return mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
  endfunction

  function automatic logic m_freeze(input int a, input logic mreq);
    return mreq && (a < MEM_LAT - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= 0;
`ifdef HAZARD_STATS_EN
      m_stall_cnt <= 0;
      m_flush_cnt <= 0;
`endif
    end else begin
      automatic logic fz = m_freeze(age, hif.mem_req);
      age <= fz ? age + 1 : 0;
`ifdef HAZARD_STATS_EN
      begin
        automatic logic l = m_lu(hif.id_opcode, hif.id_rs1, hif.id_rs2, hif.ex_MR, hif.ex_rd);
        if ((fz || (l && !hif.ex_redirect)) && m_stall_cnt < 65535) m_stall_cnt <= m_stall_cnt + 1;
        if (hif.ex_redirect && !fz && m_flush_cnt < 65535) m_flush_cnt <= m_flush_cnt + 1;
      end
`endif
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    automatic logic fz   = m_freeze(age, hif.mem_req);
    automatic logic l    = m_lu(hif.id_opcode, hif.id_rs1, hif.id_rs2, hif.ex_MR, hif.ex_rd);
    automatic logic redo = hif.ex_redirect && !fz;
    automatic logic e_stall, e_pc, e_pipe, e_flush;
    if (!rst) begin
      e_stall = 1'b1; e_pc = 1'b0; e_pipe = 1'b0; e_flush = 1'b0;
    end else begin
      e_stall = l && !fz && !hif.ex_redirect;
      e_pipe  = !fz;
      e_pc    = !fz && (redo || !l);
      e_flush = redo;
    end
    check("m_stall",      32'(hif.stall),      32'(e_stall));
    check("m_pc_en",      32'(hif.pc_en),      32'(e_pc));
    check("m_ifid_en",    32'(hif.ifid_en),    32'(e_pc));
    check("m_pipe_en",    32'(hif.pipe_en),    32'(e_pipe));
    check("m_ifid_flush", 32'(hif.ifid_flush), 32'(e_flush));
    check("m_idex_flush", 32'(hif.idex_flush), 32'(e_flush));
`ifdef HAZARD_STATS_EN
    check("m_stat_stall", 32'(hif.stat_stall_cnt), 32'(m_stall_cnt));
    check("m_stat_flush", 32'(hif.stat_flush_cnt), 32'(m_flush_cnt));
`endif
  end

  task automatic set_in(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic mr, input logic [4:0] rd, input logic redir, input logic mreq);
    hif.id_opcode   = op;
    hif.id_rs1      = rs1;
    hif.id_rs2      = rs2;
    hif.ex_MR       = mr;
    hif.ex_rd       = rd;
    hif.ex_redirect = redir;
    hif.mem_req     = mreq;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic pc, input logic pe,
                            input logic fl);
    @(negedge clk);
    check({tag, "_stall"},   32'(hif.stall),      32'(st));
    check({tag, "_pc_en"},   32'(hif.pc_en),      32'(pc));
    check({tag, "_ifid_en"}, 32'(hif.ifid_en),    32'(pc));
    check({tag, "_pipe_en"}, 32'(hif.pipe_en),    32'(pe));
    check({tag, "_flush"},   32'(hif.ifid_flush), 32'(fl));
    check({tag, "_xflush"},  32'(hif.idex_flush), 32'(fl));
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{OP_LUI, OP_JAL, OP_R, OP_B, OP_S, OP_I, OP_LD, OP_JALR};
    set_in(OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);

    next_cycle(); rst = 1'b1;
    set_in(OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);          // LW x5 / ADD rs2=x5
    expect_out("lu_add", 1'b1, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_in(OP_R, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);  // bubble now in EX
    expect_out("lu_bubble", 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle(); set_in(OP_LUI, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    expect_out("lu_lui", 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle(); set_in(OP_R, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    expect_out("rd_zero", 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle(); set_in(OP_R, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0);
    expect_out("non_load", 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle(); set_in(OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    expect_out("redir_lu", 1'b0, 1'b1, 1'b1, 1'b1);

    // Memory op with a redirect held in EX across the freeze
    next_cycle(); set_in(OP_I, 5'd2, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    expect_out("frz_a", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    expect_out("frz_b", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    expect_out("frz_c", 1'b0, 1'b1, 1'b1, 1'b1);
    next_cycle(); set_in(OP_I, 5'd2, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1);   // back-to-back op
    expect_out("b2b_a", 1'b0, 1'b0, 1'b0, 1'b0);

    next_cycle(); rst = 1'b0;                                        // reset mid-MEMWAIT
    expect_out("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    check("rst_stat_stall", 32'(hif.stat_stall_cnt), 32'd0);
    check("rst_stat_flush", 32'(hif.stat_flush_cnt), 32'd0);
`endif
    next_cycle(); rst = 1'b1; set_in(OP_I, 5'd2, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0);
    expect_out("rst_rel", 1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if ($urandom_range(99) == 0) rst = 1'b0;
      else rst = 1'b1;
      // A frozen pipeline keeps every observed register stable.
      if (!(rst && m_freeze(age, hif.mem_req))) begin
        set_in(ops[$urandom_range(7)], 5'($urandom_range(3)), 5'($urandom_range(3)),
               1'($urandom_range(1)), 5'($urandom_range(3)),
               ($urandom_range(99) < 15), ($urandom_range(99) < 20));
      end
    end
    next_cycle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
